// File: rtl/mod_exp_ctrl_if.sv
// Bundles the job request/result signals and the Montgomery multiplier
// request/response signals shared by mod_exp_ctrl and the logic around it.
// slave : the exponentiation controller itself.
// master: whatever issues jobs and hosts the multiplier.
interface mod_exp_ctrl_if #(
   parameter int DATA_WIDTH = 192,
   parameter int EXP_WIDTH  = 192
);
   logic [DATA_WIDTH-1:0] base_mont;
   logic [DATA_WIDTH-1:0] one_mont;
   logic [DATA_WIDTH-1:0] modulus;
   logic [EXP_WIDTH-1:0]  exponent;
   logic                  in_valid;
   logic                  busy;
   logic [DATA_WIDTH-1:0] out_data;
   logic                  out_valid;
   logic [DATA_WIDTH-1:0] mm_opA;
   logic [DATA_WIDTH-1:0] mm_opB;
   logic [DATA_WIDTH-1:0] mm_opM;
   logic                  mm_in_valid;
   logic [DATA_WIDTH-1:0] mm_out_data;
   logic                  mm_out_valid;

   modport master (
      output base_mont, one_mont, modulus, exponent, in_valid,
      output mm_out_data, mm_out_valid,
      input  busy, out_data, out_valid,
      input  mm_opA, mm_opB, mm_opM, mm_in_valid
   );

   modport slave (
      input  base_mont, one_mont, modulus, exponent, in_valid,
      input  mm_out_data, mm_out_valid,
      output busy, out_data, out_valid,
      output mm_opA, mm_opB, mm_opM, mm_in_valid
   );
endinterface

// File: rtl/mod_exp_ctrl.sv
// Modular exponentiation controller: left-to-right square-and-multiply over
// the exponent bits, MSB first, driving an external Montgomery multiplier.
// Optional build macro MOD_EXP_LZ_SKIP_EN: skips the squarings (and the
// requests) for leading zero exponent bits; the result is unchanged.
module mod_exp_ctrl #(
   parameter int DATA_WIDTH = 192,
   parameter int EXP_WIDTH  = 192
) (
   input  logic          clk,
   input  logic          rst,
   mod_exp_ctrl_if.slave bus
);
   localparam int IDX_W = (EXP_WIDTH > 1) ? $clog2(EXP_WIDTH) : 1;
   localparam logic [IDX_W-1:0] IDX_TOP  = IDX_W'(EXP_WIDTH - 1);
   localparam logic [IDX_W-1:0] IDX_ZERO = {IDX_W{1'b0}};
   localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
   localparam logic [DATA_WIDTH-1:0] D_ZERO = {DATA_WIDTH{1'b0}};
   localparam logic [EXP_WIDTH-1:0]  E_ZERO = {EXP_WIDTH{1'b0}};

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      SQR_REQ  = 3'd1,
      SQR_WAIT = 3'd2,
      MUL_REQ  = 3'd3,
      MUL_WAIT = 3'd4,
      DONE     = 3'd5
   } state_t;

   state_t                state_q, state_d;
   logic [DATA_WIDTH-1:0] base_q, base_d;
   logic [DATA_WIDTH-1:0] mod_q, mod_d;
   logic [EXP_WIDTH-1:0]  exp_q, exp_d;
   logic [DATA_WIDTH-1:0] acc_q, acc_d;
   logic [IDX_W-1:0]      idx_q, idx_d;
   logic [DATA_WIDTH-1:0] opa_q, opa_d;
   logic [DATA_WIDTH-1:0] opb_q, opb_d;
   logic [DATA_WIDTH-1:0] opm_q, opm_d;
   logic                  mm_in_valid_q, mm_in_valid_d;
   logic                  out_valid_q, out_valid_d;
   logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
   logic                  busy_q, busy_d;
   state_t                adv_state_s;
   logic [IDX_W-1:0]      adv_idx_s;
   logic                  bit_s;
   logic                  issue_sqr_s;
`ifdef MOD_EXP_LZ_SKIP_EN
   logic                  started_q, started_d;
`endif

   // Where the walk goes after finishing the current exponent bit.
   always_comb begin
      bit_s = exp_q[idx_q];
      if (idx_q == IDX_ZERO) begin
         adv_state_s = DONE;
         adv_idx_s   = idx_q;
      end else begin
         adv_state_s = SQR_REQ;
         adv_idx_s   = idx_q - IDX_ONE;
      end
   end

   // Next-state, job registers and the registered outputs they imply.
   always_comb begin
      state_d       = state_q;
      base_d        = base_q;
      mod_d         = mod_q;
      exp_d         = exp_q;
      acc_d         = acc_q;
      idx_d         = idx_q;
      opa_d         = opa_q;
      opb_d         = opb_q;
      opm_d         = opm_q;
      mm_in_valid_d = 1'b0;
      out_valid_d   = 1'b0;
      out_data_d    = D_ZERO;
`ifdef MOD_EXP_LZ_SKIP_EN
      started_d     = started_q;
`endif
      case (state_q)
         IDLE: begin
            if (bus.in_valid) begin
               base_d  = bus.base_mont;
               mod_d   = bus.modulus;
               exp_d   = bus.exponent;
               acc_d   = bus.one_mont;
               idx_d   = IDX_TOP;
               state_d = SQR_REQ;
`ifdef MOD_EXP_LZ_SKIP_EN
               started_d = 1'b0;
`endif
            end else begin
               state_d = IDLE;
            end
         end
         SQR_REQ: begin
`ifdef MOD_EXP_LZ_SKIP_EN
            // Before the first 1 bit, squaring the accumulator (still one)
            // is pointless: resolve one leading bit per cycle instead.
            if (!started_q) begin
               if (bit_s) begin
                  started_d = 1'b1;
                  state_d   = MUL_REQ;
               end else begin
                  state_d = adv_state_s;
                  idx_d   = adv_idx_s;
               end
            end else begin
               state_d = SQR_WAIT;
            end
`else
            state_d = SQR_WAIT;
`endif
         end
         SQR_WAIT: begin
            if (bus.mm_out_valid) begin
               acc_d = bus.mm_out_data;
               if (bit_s) begin
                  state_d = MUL_REQ;
               end else begin
                  state_d = adv_state_s;
                  idx_d   = adv_idx_s;
               end
            end else begin
               state_d = SQR_WAIT;
            end
         end
         MUL_REQ: begin
            state_d = MUL_WAIT;
         end
         MUL_WAIT: begin
            if (bus.mm_out_valid) begin
               acc_d   = bus.mm_out_data;
               state_d = adv_state_s;
               idx_d   = adv_idx_s;
            end else begin
               state_d = MUL_WAIT;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

`ifdef MOD_EXP_LZ_SKIP_EN
      issue_sqr_s = started_d;
`else
      issue_sqr_s = 1'b1;
`endif
      // Operands are captured on entry to a request state and then held
      // untouched until the multiplier answers.
      if ((state_d == SQR_REQ) && issue_sqr_s) begin
         mm_in_valid_d = 1'b1;
         opa_d         = acc_d;
         opb_d         = acc_d;
         opm_d         = mod_d;
      end else if (state_d == MUL_REQ) begin
         mm_in_valid_d = 1'b1;
         opa_d         = acc_d;
         opb_d         = base_d;
         opm_d         = mod_d;
      end else begin
         mm_in_valid_d = 1'b0;
      end

      if (state_d == DONE) begin
         out_valid_d = 1'b1;
         out_data_d  = acc_d;
      end else begin
         out_valid_d = 1'b0;
      end
      busy_d = (state_d != IDLE);
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= IDLE;
         base_q        <= D_ZERO;
         mod_q         <= D_ZERO;
         exp_q         <= E_ZERO;
         acc_q         <= D_ZERO;
         idx_q         <= IDX_ZERO;
         opa_q         <= D_ZERO;
         opb_q         <= D_ZERO;
         opm_q         <= D_ZERO;
         mm_in_valid_q <= 1'b0;
         out_valid_q   <= 1'b0;
         out_data_q    <= D_ZERO;
         busy_q        <= 1'b0;
`ifdef MOD_EXP_LZ_SKIP_EN
         started_q     <= 1'b0;
`endif
      end else begin
         state_q       <= state_d;
         base_q        <= base_d;
         mod_q         <= mod_d;
         exp_q         <= exp_d;
         acc_q         <= acc_d;
         idx_q         <= idx_d;
         opa_q         <= opa_d;
         opb_q         <= opb_d;
         opm_q         <= opm_d;
         mm_in_valid_q <= mm_in_valid_d;
         out_valid_q   <= out_valid_d;
         out_data_q    <= out_data_d;
         busy_q        <= busy_d;
`ifdef MOD_EXP_LZ_SKIP_EN
         started_q     <= started_d;
`endif
      end
   end

   assign bus.busy        = busy_q;
   assign bus.out_valid   = out_valid_q;
   assign bus.out_data    = out_data_q;
   assign bus.mm_opA      = opa_q;
   assign bus.mm_opB      = opb_q;
   assign bus.mm_opM      = opm_q;
   assign bus.mm_in_valid = mm_in_valid_q;
endmodule

// File: tb/tb_mod_exp_ctrl.sv
// Bench for mod_exp_ctrl with M=13, R=256 and a 10-cycle Montgomery
// multiplier model. Expected results come from plain modular arithmetic.
module tb_mod_exp_ctrl;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   errors = 0;
   int   checks = 0;

   mod_exp_ctrl_if #(.DATA_WIDTH(8), .EXP_WIDTH(8)) bus ();

   mod_exp_ctrl #(.DATA_WIDTH(8), .EXP_WIDTH(8)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   // Multiplier model, monitors and stray-response injection
   logic       model_valid = 1'b0;
   logic [7:0] model_data  = 8'd0;
   logic       stray_valid = 1'b0;
   logic [7:0] stray_data  = 8'd0;
   int         pend = 0;
   int         req_cnt = 0;
   int         pulse_err = 0;
   int         stab_err = 0;
   int         zero_err = 0;
   logic       prev_req = 1'b0;
   logic [7:0] cap_a, cap_b, cap_m, res;

   assign bus.mm_out_valid = model_valid | stray_valid;
   assign bus.mm_out_data  = stray_valid ? stray_data : model_data;

   always @(negedge clk) begin
      model_valid = 1'b0;
      if (pend > 0) begin
         if (bus.busy && ((bus.mm_opA !== cap_a) || (bus.mm_opB !== cap_b) || (bus.mm_opM !== cap_m)))
            stab_err++;
         pend--;
         if (pend == 0) begin
            model_valid = 1'b1;
            model_data  = res;
         end
      end
      if (bus.mm_in_valid === 1'b1) begin
         req_cnt++;
         if (prev_req) pulse_err++;
         cap_a = bus.mm_opA;
         cap_b = bus.mm_opB;
         cap_m = bus.mm_opM;
         // a*b*R^-1 mod 13, R^-1 = 3 (256*3 = 768 = 59*13 + 1)
         res  = 8'((int'(cap_a) * int'(cap_b) * 3) % 13);
         pend = 10;
      end
      prev_req = bus.mm_in_valid;
      if (!bus.out_valid && (bus.out_data !== 8'd0)) zero_err++;
   end

   // Reference: decode base from Montgomery form, plain power, re-encode.
   function automatic logic [7:0] ref_result(input logic [7:0] b, input logic [7:0] e);
      int plain = (int'(b) * 3) % 13;
      int p = 1;
      for (int i = 0; i < int'(e); i++) p = (p * plain) % 13;
      return 8'((p * 256) % 13);
   endfunction

   function automatic int ref_reqs(input logic [7:0] e);
      int pc = 0;
      int msb = -1;
      for (int i = 0; i < 8; i++) if (e[i]) begin pc++; msb = i; end
`ifdef MOD_EXP_LZ_SKIP_EN
      return (msb < 0) ? 0 : msb + pc;
`else
      return 8 + pc;
`endif
   endfunction

   task automatic run_job(input logic [7:0] b, input logic [7:0] e, input bit reissue,
                          input bit stray, output int pulses, output logic [7:0] data,
                          output int reqs);
      int cyc = 0;
      bit fin = 1'b0;
      pulses = 0;
      data   = 8'd0;
      @(negedge clk);
      req_cnt       = 0;
      bus.base_mont = b;
      bus.one_mont  = 8'd9;
      bus.modulus   = 8'd13;
      bus.exponent  = e;
      bus.in_valid  = 1'b1;
      @(negedge clk);
      bus.in_valid  = 1'b0;
      bus.base_mont = 8'($urandom);
      bus.one_mont  = 8'($urandom);
      bus.modulus   = 8'($urandom);
      bus.exponent  = 8'($urandom);
      while (!fin && cyc < 600) begin
         @(negedge clk);
         cyc++;
         bus.in_valid = reissue && ((cyc == 4) || (cyc == 30));
         if (reissue) begin
            bus.base_mont = 8'd5;
            bus.exponent  = 8'h03;
            bus.one_mont  = 8'd2;
         end
         stray_data  = 8'($urandom_range(0, 12));
         stray_valid = stray && bus.mm_in_valid;
         if (bus.out_valid) begin
            pulses++;
            data = bus.out_data;
         end
         if (pulses > 0 && !bus.busy) fin = 1'b1;
      end
      stray_valid  = 1'b0;
      bus.in_valid = 1'b0;
      repeat (5) begin
         @(negedge clk);
         if (bus.out_valid) pulses++;
      end
      reqs = req_cnt;
   endtask

   task automatic check_job(input string name, input logic [7:0] b, input logic [7:0] e,
                            input bit reissue, input bit stray);
      int pulses, reqs;
      logic [7:0] data;
      logic [7:0] exp_d = ref_result(b, e);
      int exp_r = ref_reqs(e);
      run_job(b, e, reissue, stray, pulses, data, reqs);
      checks++;
      if (pulses !== 1) begin
         errors++;
         $display("FAIL %s pulses: got %0d want 1", name, pulses);
      end
      checks++;
      if (data !== exp_d) begin
         errors++;
         $display("FAIL %s out_data: got %0d want %0d", name, data, exp_d);
      end
      checks++;
      if (reqs !== exp_r) begin
         errors++;
         $display("FAIL %s requests: got %0d want %0d", name, reqs, exp_r);
      end
   endtask

   task automatic test_reset();
      bus.in_valid  = 1'b0;
      bus.base_mont = 8'd0;
      bus.one_mont  = 8'd0;
      bus.modulus   = 8'd0;
      bus.exponent  = 8'd0;
      rst = 1'b1;
      repeat (3) @(negedge clk);
      checks++;
      if ({bus.busy, bus.out_valid, bus.mm_in_valid} !== 3'b000) begin
         errors++;
         $display("FAIL reset_flags: got %b want 000", {bus.busy, bus.out_valid, bus.mm_in_valid});
      end
      checks++;
      if ({bus.out_data, bus.mm_opA, bus.mm_opB, bus.mm_opM} !== 32'd0) begin
         errors++;
         $display("FAIL reset_data: got %h want 0", {bus.out_data, bus.mm_opA, bus.mm_opB, bus.mm_opM});
      end
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_basic();
      check_job("basic_e5", 8'd1, 8'd5, 1'b0, 1'b0);
      check_job("exp_zero", 8'd1, 8'd0, 1'b0, 1'b0);
      check_job("exp_ff", 8'd1, 8'hFF, 1'b0, 1'b0);
   endtask

   task automatic test_busy_reissue();
      check_job("reissue", 8'd1, 8'd5, 1'b1, 1'b0);
   endtask

   task automatic test_stray();
      // Stray response while idle must not start or finish anything.
      @(negedge clk);
      stray_data  = 8'd7;
      stray_valid = 1'b1;
      @(negedge clk);
      stray_valid = 1'b0;
      repeat (3) @(negedge clk);
      checks++;
      if ({bus.busy, bus.out_valid, bus.mm_in_valid} !== 3'b000) begin
         errors++;
         $display("FAIL stray_idle: got %b want 000", {bus.busy, bus.out_valid, bus.mm_in_valid});
      end
      check_job("stray_req", 8'd1, 8'd5, 1'b0, 1'b1);
   endtask

   task automatic test_abort();
      int guard = 0;
      int bad = 0;
      @(negedge clk);
      bus.base_mont = 8'd1;
      bus.one_mont  = 8'd9;
      bus.modulus   = 8'd13;
      bus.exponent  = 8'h85;
      bus.in_valid  = 1'b1;
      @(negedge clk);
      bus.in_valid = 1'b0;
      while (pend == 0 && guard < 50) begin
         @(negedge clk);
         guard++;
      end
      checks++;
      if (pend == 0) begin
         errors++;
         $display("FAIL abort_wait: got no request want one within 50 cycles");
      end
      repeat (3) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      checks++;
      if ({bus.busy, bus.mm_in_valid, bus.mm_opA, bus.mm_opB, bus.mm_opM} !== 26'd0) begin
         errors++;
         $display("FAIL abort_reset_state: got %h want 0",
                  {bus.busy, bus.mm_in_valid, bus.mm_opA, bus.mm_opB, bus.mm_opM});
      end
      repeat (20) begin
         @(negedge clk);
         if (bus.busy || bus.out_valid || bus.mm_in_valid) bad++;
      end
      checks++;
      if (bad !== 0) begin
         errors++;
         $display("FAIL abort_idle: got %0d active cycles want 0", bad);
      end
      check_job("after_abort", 8'd1, 8'd5, 1'b0, 1'b0);
   endtask

   task automatic test_random();
      for (int i = 0; i < 6; i++) begin
         logic [7:0] b = 8'($urandom_range(0, 12));
         logic [7:0] e = 8'($urandom_range(0, 255));
         check_job("random", b, e, 1'b0, 1'b0);
      end
   endtask

   task automatic test_invariants();
      checks++;
      if (pulse_err !== 0) begin
         errors++;
         $display("FAIL req_pulse_width: got %0d long pulses want 0", pulse_err);
      end
      checks++;
      if (stab_err !== 0) begin
         errors++;
         $display("FAIL operand_stability: got %0d changes want 0", stab_err);
      end
      checks++;
      if (zero_err !== 0) begin
         errors++;
         $display("FAIL out_data_zero: got %0d nonzero cycles want 0", zero_err);
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_busy_reissue();
      test_stray();
      test_abort();
      test_random();
      test_invariants();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/mod_exp_ctrl.md
MOD_EXP_CTRL -- requirements
Module: mod_exp_ctrl

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 192, operand/modulus width.
REQ-002 SHALL have parameter EXP_WIDTH, default 192, exponent width.
REQ-003 SHALL have port clk  input  1  single clock, all logic on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have ports base_mont, one_mont, modulus  input  DATA_WIDTH  base in Montgomery form, R mod M, modulus M.
REQ-006 SHALL have port exponent  input  EXP_WIDTH  exponent e.
REQ-007 SHALL have ports in_valid input 1 (start request) and busy output 1 (high whenever state is not IDLE).
REQ-008 SHALL have ports out_data  output  DATA_WIDTH  and out_valid  output  1  (base^e in Montgomery form).
REQ-009 SHALL have ports mm_opA, mm_opB, mm_opM  output  DATA_WIDTH  and mm_in_valid  output  1, driving the Montgomery multiplier.
REQ-010 SHALL have ports mm_out_data  input  DATA_WIDTH  and mm_out_valid  input  1, the multiplier result.

Function
REQ-011 SHALL implement states IDLE, SQR_REQ, SQR_WAIT, MUL_REQ, MUL_WAIT, DONE; left-to-right square-and-multiply over exponent bits EXP_WIDTH-1 down to 0.
REQ-012 IDLE with in_valid=1 SHALL register base_mont, one_mont, modulus, exponent; set acc=one_mont, idx=EXP_WIDTH-1; go SQR_REQ next cycle.
REQ-013 in_valid while busy SHALL be ignored; no operand register changes.
REQ-014 SQR_REQ SHALL drive mm_in_valid=1 for exactly one cycle with mm_opA=mm_opB=acc, mm_opM=modulus; go SQR_WAIT.
REQ-015 MUL_REQ SHALL drive mm_in_valid=1 for exactly one cycle with mm_opA=acc, mm_opB=base, mm_opM=modulus; go MUL_WAIT.
REQ-016 mm_opA/mm_opB/mm_opM SHALL be registered and held stable from the request cycle until the matching mm_out_valid.
REQ-017 SQR_WAIT on mm_out_valid SHALL load acc=mm_out_data; go MUL_REQ if exponent[idx]=1, else advance.
REQ-018 MUL_WAIT on mm_out_valid SHALL load acc=mm_out_data and advance.
REQ-019 Advance: idx=0 -> DONE; else idx decrements, go SQR_REQ.
REQ-020 DONE SHALL assert out_valid=1 and out_data=acc for exactly one cycle, then IDLE.
REQ-021 out_data SHALL be zero whenever out_valid=0.
REQ-022 mm_out_valid outside SQR_WAIT/MUL_WAIT SHALL be ignored (no acc or state change).
REQ-023 Wait states SHALL have no timeout; controller waits indefinitely for mm_out_valid.
REQ-024 Request count without skip: EXP_WIDTH squarings plus popcount(exponent) multiplies.

Reset
REQ-025 rst=1 at a clock edge SHALL force IDLE, busy=0, out_valid=0, out_data=0, mm_in_valid=0, mm_opA/B/M=0, acc=0, idx=0.
REQ-026 rst mid-operation SHALL abort the job; a later stray mm_out_valid SHALL be ignored per REQ-022.

Configuration
REQ-027 Macro MOD_EXP_LZ_SKIP_EN SHALL, when defined, add a started flag (cleared on accept): while started=0, squarings are skipped; zero bits advance in one cycle with no request; the first 1 bit goes directly to MUL_REQ and sets started.
REQ-028 Without MOD_EXP_LZ_SKIP_EN, every bit SHALL issue a squaring per REQ-024; final out_data SHALL be identical either way.
REQ-029 With the macro, exponent=0 SHALL reach DONE with zero multiplier requests and out_data=one_mont.

Verification (DATA_WIDTH=8, EXP_WIDTH=8, M=13, R=256; bench model returns fully reduced a*b*R^-1 mod 13, latency 10 cycles)
REQ-030 base_mont=1 (3*R mod 13), one_mont=9, exponent=5 -> one out_valid pulse, out_data=3; 10 requests without macro, 4 with.
REQ-031 exponent=0 -> out_data=9; 8 squarings without macro, 0 requests with macro.
REQ-032 in_valid pulsed again during busy with different operands -> ignored; result still 3 for REQ-030 stimulus.
REQ-033 rst asserted in SQR_WAIT, multiplier still returns mm_out_valid -> stays IDLE, no out_valid; next job gives correct result.
REQ-034 mm_out_valid injected in IDLE and during SQR_REQ -> no state/acc change; mm_opA/B/M stable across every wait.
REQ-035 exponent=8'hFF, base_mont=1 -> out_data=3^255*R mod 13 per model; every request has mm_in_valid high exactly one cycle.
